// File: rtl/wts_bus_pkg.sv
// rtl/wts_bus_pkg.sv - shared widths and FSM state type for the slot-bus front end
package wts_bus_pkg;

  localparam int SLOT_ADDR_W = 16;
  localparam int SLOT_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_WAIT  = 2'd1,
    ST_RD_DRIVE = 2'd2,
    ST_RELEASE  = 2'd3
  } bus_state_t;

endpackage

// File: rtl/wts_sync_ff.sv
// rtl/wts_sync_ff.sv - single-bit N-stage synchroniser with configurable reset value
module wts_sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain; reset loads the inactive level
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/wts_slot_bus_if.sv
// rtl/wts_slot_bus_if.sv - MSX slot-bus front end: strobe sync, access FSM, read-data pad drive
module wts_slot_bus_if
  import wts_bus_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SLOT_ADDR_W-1:0] slot_a,
  input  logic [SLOT_DATA_W-1:0] slot_d_in,
  output logic [SLOT_DATA_W-1:0] slot_d_out,
  output logic                   slot_d_oe,
  input  logic                   slot_nsltsl,
  input  logic                   slot_nmerq,
  input  logic                   slot_nrd,
  input  logic                   slot_nwr,
  output logic [SLOT_ADDR_W-1:0] bus_address,
  output logic [SLOT_DATA_W-1:0] bus_wdata,
  output logic                   bus_write,
  output logic                   bus_read,
  input  logic [SLOT_DATA_W-1:0] bus_rdata,
  input  logic                   bus_rdata_en,
  output logic                   bus_active
);

  logic w_nsltsl_s, w_nmerq_s, w_nrd_s, w_nwr_s;
  logic w_sel_s, w_rd_s, w_wr_s;

  bus_state_t r_state, w_state_nxt;
  logic       w_do_write, w_do_read, w_capture, w_drop;

  logic [1:0]             r_settle;
  logic [SLOT_ADDR_W-1:0] r_address;
  logic [SLOT_DATA_W-1:0] r_wdata;
  logic [SLOT_DATA_W-1:0] r_d_out;
  logic                   r_write, r_read, r_drive_q;

  wts_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nsltsl (
    .i_clk(clk), .i_reset(reset), .i_d(slot_nsltsl), .o_q(w_nsltsl_s));
  wts_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nmerq (
    .i_clk(clk), .i_reset(reset), .i_d(slot_nmerq), .o_q(w_nmerq_s));
  wts_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nrd (
    .i_clk(clk), .i_reset(reset), .i_d(slot_nrd), .o_q(w_nrd_s));
  wts_sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_nwr (
    .i_clk(clk), .i_reset(reset), .i_d(slot_nwr), .o_q(w_nwr_s));

  assign w_sel_s = ~w_nsltsl_s & ~w_nmerq_s;
  assign w_rd_s  = ~w_nrd_s;
  assign w_wr_s  = ~w_nwr_s;

  // Post-reset settle count: the synchronisers restart at the inactive level, so ST_RELEASE
  // must not trust a low sel_s until the real pin levels have filled the chains. Otherwise
  // an access that straddles reset would reappear as a fresh strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_settle <= 2'(SYNC_STAGES);
    end else if (r_settle != 2'd0) begin
      r_settle <= r_settle - 2'd1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RELEASE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle actions
  always_comb begin
    w_state_nxt = r_state;
    w_do_write  = 1'b0;
    w_do_read   = 1'b0;
    w_capture   = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel_s && w_wr_s && !w_rd_s) begin
          w_do_write  = 1'b1;
          w_state_nxt = ST_RELEASE;
        end else if (w_sel_s && w_rd_s && !w_wr_s) begin
          w_do_read   = 1'b1;
          w_state_nxt = ST_RD_WAIT;
        end else if (w_sel_s && w_rd_s && w_wr_s) begin
          w_state_nxt = ST_RELEASE;
        end
      end
      // The consumer answers on the cycle after bus_read, so skip the cycle the pulse is high
      ST_RD_WAIT: begin
        if (!r_read) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_RD_DRIVE;
        end
      end
      ST_RD_DRIVE: begin
        if (!w_sel_s || !w_rd_s) begin
          w_drop      = 1'b1;
          w_state_nxt = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if ((r_settle == 2'd0) && !w_sel_s) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_RELEASE;
    endcase
  end

  // Strobes, latched address/data, captured read response and drive enable
  always_ff @(posedge clk) begin
    if (reset) begin
      r_address <= '0;
      r_wdata   <= '0;
      r_write   <= 1'b0;
      r_read    <= 1'b0;
      r_d_out   <= '0;
      r_drive_q <= 1'b0;
    end else begin
      r_write <= w_do_write;
      r_read  <= w_do_read;
      if (w_do_write || w_do_read) begin
        r_address <= slot_a;
      end
      if (w_do_write) begin
        r_wdata <= slot_d_in;
      end
      if (w_capture) begin
        r_d_out   <= bus_rdata;
        r_drive_q <= bus_rdata_en;
      end else if (w_drop) begin
        r_drive_q <= 1'b0;
      end
    end
  end

  // Raw-pin gating drops the pad as soon as the host releases nRD or deselects the slot
  assign slot_d_oe   = r_drive_q & ~slot_nrd & ~slot_nsltsl;
  assign slot_d_out  = r_d_out;
  assign bus_address = r_address;
  assign bus_wdata   = r_wdata;
  assign bus_write   = r_write;
  assign bus_read    = r_read;
  assign bus_active  = w_sel_s;

endmodule

// File: doc/wts_slot_bus_if.md
# wts_slot_bus_if

Slot-bus front end for the wave-table-sound cartridge. It synchronises the asynchronous MSX slot strobes to `clk` and latches address and write data. It issues single-cycle internal read and write strobes to the bank-register / SCC register decoder, and drives the slot data bus during internal register reads. It sits between the cartridge pins and the mapper / sound-register logic in `wts_for_cartridge`.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: flip-flop depth of each strobe synchroniser. Legal values are 2–3.

Ports:
- `clk`, in, 1: system clock, 21.47727 MHz.
- `reset`, in, 1: one clock; reset is synchronous and active-high.
- `slot_a`, in, 16: slot address.
- `slot_d_in`, in, 8: slot data from the pad.
- `slot_d_out`, out, 8: slot data to the pad.
- `slot_d_oe`, out, 1: pad output enable. When 0, the pad is Hi-Z.
- `slot_nsltsl`, `slot_nmerq`, `slot_nrd`, `slot_nwr`, in, 1 each: active-low slot strobes. They are asynchronous to `clk`.
- `bus_address`, out, 16: address latched for the current access.
- `bus_wdata`, out, 8: write data latched for the current access.
- `bus_write`, out, 1: one-cycle write strobe.
- `bus_read`, out, 1: one-cycle read strobe.
- `bus_rdata`, in, 8: read data from the consumer. It is valid on the cycle after `bus_read`.
- `bus_rdata_en`, in, 1: consumer claims the read, qualified with `bus_rdata`. When 0, external memory answers and this block keeps the pad Hi-Z.
- `bus_active`, out, 1: a slot access is in progress (`sel_s` high, see below).

## Operation
Synchronisation:
- Each of the four strobes passes through a `SYNC_STAGES`-deep synchroniser. Synchroniser reset value is 1, which means inactive.
- Define `sel_s = ~nsltsl_s & ~nmerq_s`, `rd_s = ~nrd_s`, `wr_s = ~nwr_s`.

FSM states: `ST_IDLE`, `ST_RD_WAIT`, `ST_RD_DRIVE`, `ST_RELEASE`. The reset state is `ST_RELEASE`.
- **ST_IDLE**
  - If `sel_s & wr_s & ~rd_s`: latch `slot_a` into `bus_address` and `slot_d_in` into `bus_wdata`, pulse `bus_write`, go to `ST_RELEASE`.
  - If `sel_s & rd_s & ~wr_s`: latch `slot_a`, pulse `bus_read`, go to `ST_RD_WAIT`.
  - If `sel_s & rd_s & wr_s` (illegal): no strobe, go to `ST_RELEASE`.
- **ST_RD_WAIT**: register `bus_rdata` into `slot_d_out` and `bus_rdata_en` into `drive_q`, then go to `ST_RD_DRIVE`.
- **ST_RD_DRIVE**: hold. When `~sel_s | ~rd_s`, clear `drive_q` and go to `ST_RELEASE`.
- **ST_RELEASE**: when `~sel_s`, go to `ST_IDLE`. This guarantees at most one strobe per slot cycle. It also guarantees that reset in the middle of an access never yields a partial strobe.

Output drive:
- `slot_d_oe = drive_q & ~slot_nrd & ~slot_nsltsl`.
- The raw-pin gating releases the bus with combinational delay only, with no clock latency.

Reset values: all outputs are 0, `drive_q` is 0, and the FSM is in `ST_RELEASE`.

## Timing
- A strobe sampled low at edge k reaches `*_s` at edge k+SYNC_STAGES-1. `bus_write` / `bus_read` is high for exactly one cycle after edge k+SYNC_STAGES.
- `bus_address` and `bus_wdata` update on the same edge as the strobe and hold until the next accepted access.
- Read path: `slot_d_out` and `slot_d_oe` are valid 2 cycles after `bus_read`. With SYNC_STAGES=2 this is ≤ 5 clk (233 ns) after `slot_nrd` falls, which is inside the Z80 read window.
- Z80 minimum strobe width (~280 ns) is ≥ 6 clk, so every access is detected.
- Back-to-back accesses need ≥ 1 clk of `sel_s` inactive between them to be seen as separate.
- A `reset` assertion during `ST_RD_DRIVE` drops `slot_d_oe` on the next edge.

## Structure
- Package `wts_bus_pkg` holds:
  - the `bus_state_t` enum (4 states, 2-bit encoding);
  - `SLOT_ADDR_W = 16` and `SLOT_DATA_W = 8`.
- Sub-module `wts_sync_ff`: a single-bit N-stage synchroniser with parameterised reset value. It is instantiated four times.

## Test plan
- **Write**: write 0x5000 ← 0x2A with Z80 timing (nmerq low at +145 ns, nwr low 140 ns into T2) → exactly one `bus_write` pulse, `bus_address` = 0x5000, `bus_wdata` = 0x2A, and `slot_d_oe` stays 0 throughout.
- **Claimed read**: read 0x9800 with the consumer returning `bus_rdata_en` = 1 and `bus_rdata` = 0xC3 one cycle after `bus_read` → `slot_d` = 0xC3 before `slot_nrd` rises, and the pad returns to Hi-Z within combinational delay of `slot_nrd` rising.
- **Unclaimed read**: read 0x4001 with `bus_rdata_en` = 0 → one `bus_read` pulse, `bus_address` = 0x4001, `slot_d` stays Hi-Z.
- **Not selected**: `slot_nmerq` low with `slot_nsltsl` high, and `slot_nwr` low → no strobe, `bus_active` = 0.
- **Reset mid-access**: assert `reset` for 3 clk during a read while `slot_d_oe` = 1 → `slot_d_oe` = 0 on the first reset edge. There is no strobe for the remainder of that access, and the next access (write 0x7000 ← 0x03) produces a normal single `bus_write`.
- **Illegal strobes**: `slot_nrd` and `slot_nwr` both low while selected → no strobes and no drive. A following legal write is still accepted.
